cmd_exec_burst: RTL and testbench

//  Parametrised successor of the command execute stage. Pops a framed command from the UART byte FIFO,

---
 rtl/cmd_exec_burst_if.sv | 34 +++
 rtl/cmd_exec_burst.sv | 203 ++++++++++++++++++++
 tb/tb_cmd_exec_burst.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_exec_burst_if.sv
// Byte FIFO, response FIFO and memory port signals of the command execute stage.
// The master side is the execute stage. The slave side is the FIFOs and memory around it.
interface cmd_exec_burst_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) ();
   logic              byte_fifo_valid;
   logic [7:0]        byte_fifo_data;
   logic              byte_fifo_rd_en;
   logic              cmd_resp_full;
   logic [7:0]        cmd_resp_wr_data;
   logic              cmd_resp_wr_en;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  byte_fifo_valid, byte_fifo_data, cmd_resp_full,
             mem_gnt, mem_rvalid, mem_rdata,
      output byte_fifo_rd_en, cmd_resp_wr_data, cmd_resp_wr_en,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output byte_fifo_valid, byte_fifo_data, cmd_resp_full,
             mem_gnt, mem_rvalid, mem_rdata,
      input  byte_fifo_rd_en, cmd_resp_wr_data, cmd_resp_wr_en,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cmd_exec_burst.sv
// Command execute stage with burst support.
// Each command frame is popped from the RX byte FIFO. The stage then runs single or burst
// memory reads/writes and pushes response bytes into the TX FIFO. The TX FIFO can apply
// backpressure. A stall partway through a frame ends the frame with a timeout.
module cmd_exec_burst #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   cmd_exec_burst_if.master    bus,
   output logic                busy
);
   localparam int ADDR_B = ADDR_W / 8;
   localparam int DATA_B = DATA_W / 8;
   localparam logic [7:0] ADDR_LAST = 8'(ADDR_B - 1);
   localparam logic [7:0] DATA_LAST = 8'(DATA_B - 1);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [3:0] {
      IDLE, ADDR, LEN, WDATA, WREQ, RREQ, RWAIT, RSEND, RESP
   } state_t;

   state_t            state_reg;
   state_t            ret_reg;        // state to enter after a RESP byte is pushed
   logic              is_write_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        len_reg;
   logic [7:0]        word_cnt_reg;
   logic [7:0]        byte_cnt_reg;
   logic [7:0]        tx_byte_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rbuf_reg;
   logic              mem_req_reg;
   logic              mem_we_reg;

   logic in_rx, in_frame, pop, push, starved, tmo_hit;

   assign in_frame = (state_reg == ADDR) || (state_reg == LEN) || (state_reg == WDATA);
   assign in_rx    = (state_reg == IDLE) || in_frame;
   assign pop      = bus.byte_fifo_valid & in_rx;
   assign push     = ((state_reg == RESP) || (state_reg == RSEND)) & ~bus.cmd_resp_full;
   assign starved  = in_frame & ~bus.byte_fifo_valid;

   assign bus.byte_fifo_rd_en  = pop;
   assign bus.cmd_resp_wr_en   = push;
   assign bus.cmd_resp_wr_data = (state_reg == RSEND) ? rbuf_reg[DATA_W-1 -: 8] : tx_byte_reg;
   assign bus.mem_req          = mem_req_reg;
   assign bus.mem_we           = mem_we_reg;
   assign bus.mem_addr         = addr_reg;
   assign bus.mem_wdata        = wdata_reg;
   assign busy                 = (state_reg != IDLE);

   generate
      if (TIMEOUT_CYC > 0) begin : g_tmo
         logic [TW-1:0] tmo_cnt_reg;
         assign tmo_hit = starved && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
         // Count consecutive starved cycles inside a frame. Any pop or state change clears the count.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               tmo_cnt_reg <= '0;
            else if (starved && !tmo_hit)
               tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            else
               tmo_cnt_reg <= '0;
         end
      end else begin : g_no_tmo
         assign tmo_hit = 1'b0;
      end
   endgenerate

   // Main control FSM: frame parsing, memory handshakes and response sequencing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         ret_reg      <= IDLE;
         is_write_reg <= 1'b0;
         addr_reg     <= '0;
         len_reg      <= '0;
         word_cnt_reg <= '0;
         byte_cnt_reg <= '0;
         tx_byte_reg  <= '0;
         wdata_reg    <= '0;
         rbuf_reg     <= '0;
         mem_req_reg  <= 1'b0;
         mem_we_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  byte_cnt_reg <= '0;
                  ret_reg      <= IDLE;
                  case (bus.byte_fifo_data)
                     8'h57: begin is_write_reg <= 1'b1; state_reg <= ADDR; end
                     8'h52: begin is_write_reg <= 1'b0; state_reg <= ADDR; end
                     8'h50: begin tx_byte_reg <= 8'h50; state_reg <= RESP; end
                     default: begin tx_byte_reg <= 8'hEE; state_reg <= RESP; end
                  endcase
               end
            end
            ADDR: begin
               if (pop) begin
                  addr_reg <= (addr_reg << 8) | ADDR_W'(bus.byte_fifo_data);
                  if (byte_cnt_reg == ADDR_LAST) begin
                     byte_cnt_reg <= '0;
                     state_reg    <= LEN;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  end
               end else if (tmo_hit) begin
                  tx_byte_reg <= 8'hEE; ret_reg <= IDLE; state_reg <= RESP;
               end
            end
            LEN: begin
               if (pop) begin
                  len_reg      <= bus.byte_fifo_data;
                  word_cnt_reg <= '0;
                  byte_cnt_reg <= '0;
                  if (is_write_reg) begin
                     state_reg <= WDATA;
                  end else begin
                     // Read header goes out before the first memory request.
                     tx_byte_reg <= 8'hA5; ret_reg <= RREQ; state_reg <= RESP;
                  end
               end else if (tmo_hit) begin
                  tx_byte_reg <= 8'hEE; ret_reg <= IDLE; state_reg <= RESP;
               end
            end
            WDATA: begin
               if (pop) begin
                  wdata_reg <= (wdata_reg << 8) | DATA_W'(bus.byte_fifo_data);
                  if (byte_cnt_reg == DATA_LAST) begin
                     byte_cnt_reg <= '0;
                     mem_req_reg  <= 1'b1;
                     mem_we_reg   <= 1'b1;
                     state_reg    <= WREQ;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  end
               end else if (tmo_hit) begin
                  tx_byte_reg <= 8'hEE; ret_reg <= IDLE; state_reg <= RESP;
               end
            end
            WREQ: begin
               if (bus.mem_gnt) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  addr_reg    <= addr_reg + 1'b1;
                  if (word_cnt_reg == len_reg) begin
                     tx_byte_reg <= 8'hA5; ret_reg <= IDLE; state_reg <= RESP;
                  end else begin
                     word_cnt_reg <= word_cnt_reg + 1'b1;
                     state_reg    <= WDATA;
                  end
               end
            end
            RREQ: begin
               if (bus.mem_gnt) begin
                  mem_req_reg <= 1'b0;
                  addr_reg    <= addr_reg + 1'b1;
                  state_reg   <= RWAIT;
               end
            end
            RWAIT: begin
               if (bus.mem_rvalid) begin
                  rbuf_reg     <= bus.mem_rdata;
                  byte_cnt_reg <= '0;
                  state_reg    <= RSEND;
               end
            end
            RSEND: begin
               if (push) begin
                  rbuf_reg <= rbuf_reg << 8;
                  if (byte_cnt_reg == DATA_LAST) begin
                     byte_cnt_reg <= '0;
                     if (word_cnt_reg == len_reg) begin
                        state_reg <= IDLE;
                     end else begin
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        state_reg    <= RREQ;
                     end
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  end
               end
            end
            RESP: begin
               if (push) begin
                  state_reg <= ret_reg;
                  if (ret_reg == RREQ) begin
                     mem_req_reg <= 1'b1;
                     mem_we_reg  <= 1'b0;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cmd_exec_burst.sv
// Directed testbench for cmd_exec_burst. It models the RX FIFO, the TX FIFO and a simple memory.
module tb_cmd_exec_burst;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } macc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic gnt_allow = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] rdq[$];
    macc_t       mq[$];
    logic        rd_pend = 1'b0;
    int          busy_cnt = 0;
    int          req_cnt = 0;
    int          viol = 0;

    cmd_exec_burst_if #(.ADDR_W(16), .DATA_W(32)) ifc ();

    cmd_exec_burst #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(50)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifc.master),
        .busy (busy)
    );

    assign ifc.mem_gnt = ifc.mem_req & gnt_allow;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("[TB] PASS %s value=%0h", tag, obs);
        end
    endtask

    // FIFO and memory model: inputs change on the falling edge and outputs are sampled 1 ns later.
    always @(negedge clk) begin
        ifc.byte_fifo_valid = (rx_q.size() > 0);
        ifc.byte_fifo_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        ifc.mem_rvalid      = rd_pend;
        ifc.mem_rdata       = 32'h0;
        if (rd_pend && rdq.size() > 0) ifc.mem_rdata = rdq.pop_front();
        rd_pend = 1'b0;
        #1;
        if (ifc.byte_fifo_rd_en) void'(rx_q.pop_front());
        if (ifc.cmd_resp_wr_en) begin
            tx_q.push_back(ifc.cmd_resp_wr_data);
            if (ifc.cmd_resp_full) viol++;
            $display("[TB] tx byte %02h", ifc.cmd_resp_wr_data);
        end
        if (ifc.mem_req && ifc.mem_gnt) begin
            mq.push_back({ifc.mem_we, ifc.mem_addr, ifc.mem_wdata});
            if (!ifc.mem_we) rd_pend = 1'b1;
            $display("[TB] mem %s addr %04h wdata %08h", ifc.mem_we ? "wr" : "rd", ifc.mem_addr, ifc.mem_wdata);
        end
        if (busy) busy_cnt++;
        if (ifc.mem_req) req_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int bound, input string tag);
        int c = 0;
        while (tx_q.size() < n && c < bound) begin
            @(negedge clk); #2;
            c++;
        end
        chk(tag, tx_q.size() >= n, 1'b1);
    endtask

    task automatic clear_logs();
        tx_q.delete(); mq.delete();
        busy_cnt = 0; req_cnt = 0;
    endtask

    logic [7:0] exp_rd[9] = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] exp_bp[9] = '{8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h11, 8'h12, 8'h13, 8'h14};

    initial begin
        int c;
        int held;
        ifc.cmd_resp_full   = 1'b0;
        ifc.byte_fifo_valid = 1'b0;
        ifc.byte_fifo_data  = 8'h00;
        ifc.mem_rvalid      = 1'b0;
        ifc.mem_rdata       = 32'h0;

        // Reset state
        tick(3); #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", ifc.mem_req, 1'b0);
        chk("rst_wr_en", ifc.cmd_resp_wr_en, 1'b0);
        chk("rst_addr", ifc.mem_addr, 16'h0000);
        tick(1); rst = 1'b1;
        tick(2);

        // Ping
        clear_logs();
        rx_q.push_back(8'h50);
        wait_tx(1, 20, "ping_tx_seen");
        tick(3); #2;
        chk("ping_byte", tx_q[0], 8'h50);
        chk("ping_count", tx_q.size(), 1);
        chk("ping_busy_cycles", busy_cnt, 1);
        chk("ping_no_req", req_cnt, 0);

        // Write burst, zero-wait grant
        tick(1); clear_logs();
        rx_q = '{8'h57, 8'h00, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        wait_tx(1, 100, "wr_tx_seen");
        tick(2); #2;
        chk("wr_n_acc", mq.size(), 2);
        chk("wr_acc0", mq[0], {1'b1, 16'h0010, 32'h11223344});
        chk("wr_acc1", mq[1], {1'b1, 16'h0011, 32'h55667788});
        chk("wr_resp", tx_q[0], 8'hA5);
        chk("wr_resp_count", tx_q.size(), 1);
        chk("wr_idle", busy, 1'b0);

        // Read burst wrapping past 0xFFFF, grant held off at first
        tick(1); clear_logs();
        gnt_allow = 1'b0;
        rdq = '{32'hAABBCCDD, 32'h01020304};
        rx_q = '{8'h52, 8'hFF, 8'hFF, 8'h01};
        tick(12); #2;
        chk("rd_req_held", ifc.mem_req, 1'b1);
        chk("rd_no_acc_yet", mq.size(), 0);
        tick(1); gnt_allow = 1'b1;
        wait_tx(9, 200, "rd_tx_seen");
        tick(2); #2;
        chk("rd_n_acc", mq.size(), 2);
        chk("rd_addr0", mq[0].addr, 16'hFFFF);
        chk("rd_addr1", mq[1].addr, 16'h0000);
        chk("rd_we0", mq[0].we, 1'b0);
        for (int i = 0; i < 9; i++) chk($sformatf("rd_tx%0d", i), tx_q[i], exp_rd[i]);
        chk("rd_tx_count", tx_q.size(), 9);

        // Backpressure during read reply
        tick(1); clear_logs(); viol = 0;
        rdq = '{32'h0A0B0C0D, 32'h11121314};
        rx_q = '{8'h52, 8'h12, 8'h34, 8'h01};
        wait_tx(2, 100, "bp_tx_start");
        tick(1); ifc.cmd_resp_full = 1'b1;
        #2; held = tx_q.size();
        tick(20); #2;
        chk("bp_no_push_while_full", tx_q.size(), held);
        tick(1); ifc.cmd_resp_full = 1'b0;
        wait_tx(9, 200, "bp_tx_seen");
        tick(2); #2;
        chk("bp_viol", viol, 0);
        chk("bp_tx_count", tx_q.size(), 9);
        for (int i = 0; i < 9; i++) chk($sformatf("bp_tx%0d", i), tx_q[i], exp_bp[i]);
        chk("bp_addr1", mq[1].addr, 16'h1235);

        // Unknown opcode
        tick(1); clear_logs();
        rx_q.push_back(8'h99);
        wait_tx(1, 20, "err_tx_seen");
        chk("err_byte", tx_q[0], 8'hEE);

        // Inter-byte timeout, then ping still answered
        tick(2); clear_logs();
        rx_q = '{8'h57, 8'h00};
        c = 0;
        while (tx_q.size() < 1 && c < 200) begin
            @(negedge clk); #2;
            c++;
        end
        chk("tmo_latency_ok", (c >= 45) && (c <= 70), 1'b1);
        chk("tmo_byte", tx_q[0], 8'hEE);
        tick(2); #2;
        chk("tmo_idle", busy, 1'b0);
        tick(1); clear_logs();
        rx_q.push_back(8'h50);
        wait_tx(1, 20, "tmo_ping_seen");
        chk("tmo_ping", tx_q[0], 8'h50);

        // Reset asserted while a write request is pending
        tick(2); clear_logs();
        gnt_allow = 1'b0;
        rx_q = '{8'h57, 8'h00, 8'h20, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02, 8'h03, 8'h04};
        c = 0;
        while (!ifc.mem_req && c < 50) begin
            @(negedge clk); #2;
            c++;
        end
        chk("mrst_req_seen", ifc.mem_req, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mrst_req", ifc.mem_req, 1'b0);
        chk("mrst_we", ifc.mem_we, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_addr", ifc.mem_addr, 16'h0000);
        rx_q.delete();
        tick(2); rst = 1'b1; gnt_allow = 1'b1;
        tick(1); clear_logs();
        rx_q = '{8'h57, 8'h00, 8'h30, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        wait_tx(1, 100, "mrst_wr_tx_seen");
        tick(2); #2;
        chk("mrst_n_acc", mq.size(), 1);
        chk("mrst_acc0", mq[0], {1'b1, 16'h0030, 32'hDEADBEEF});
        chk("mrst_resp", tx_q[0], 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
